// File: rtl/reorder_buffer_pkg.sv
// Shared ROB types and defaults for dispatch, reservation stations and commit.
// Tags are entry index + 1, so tag 0 always means "no producer / value ready in RF".
package reorder_buffer_pkg;

  localparam int unsigned ROB_SIZE     = 8;
  localparam int unsigned DATA_SIZE    = 32;
  localparam int unsigned ADDRESS_SIZE = 32;
  localparam int unsigned REG_SIZE     = 5;

  // Storage-width entry; narrower instance parameters are cast into these fields.
  typedef struct packed {
    logic                    busy;
    logic                    done;
    logic                    mispredict;
    logic [REG_SIZE-1:0]     rd;
    logic [ADDRESS_SIZE-1:0] pc;
    logic [DATA_SIZE-1:0]    value;
    logic [ADDRESS_SIZE-1:0] target;
  } rob_entry_t;

  function automatic int unsigned rob_tag_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand lookup and commit signals of the reorder buffer.
interface reorder_buffer_if
  import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = ROB_SIZE,
    parameter int unsigned DATA_WIDTH   = DATA_SIZE,
    parameter int unsigned ADDR_WIDTH   = ADDRESS_SIZE,
    parameter int unsigned REG_WIDTH    = 5,
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned TAG_WIDTH    = rob_tag_width(DEPTH)
) ();

    logic                               dispatch_valid;
    logic                               dispatch_ready;
    logic [REG_WIDTH-1:0]               dispatch_rd;
    logic [ADDR_WIDTH-1:0]              dispatch_pc;
    logic [TAG_WIDTH-1:0]               dispatch_tag;

    logic                               cdb_valid;
    logic [TAG_WIDTH-1:0]               cdb_tag;
    logic [DATA_WIDTH-1:0]              cdb_value;
    logic                               cdb_mispredict;
    logic [ADDR_WIDTH-1:0]              cdb_target;

    logic [TAG_WIDTH-1:0]               lookup_tag_a;
    logic [TAG_WIDTH-1:0]               lookup_tag_b;
    logic                               lookup_ready_a;
    logic                               lookup_ready_b;
    logic [DATA_WIDTH-1:0]              lookup_value_a;
    logic [DATA_WIDTH-1:0]              lookup_value_b;

    logic [COMMIT_WIDTH-1:0]            commit_valid;
    logic [COMMIT_WIDTH*REG_WIDTH-1:0]  commit_rd;
    logic [COMMIT_WIDTH*DATA_WIDTH-1:0] commit_value;
    logic [COMMIT_WIDTH*TAG_WIDTH-1:0]  commit_tag;

    logic                               flush;
    logic [ADDR_WIDTH-1:0]              flush_pc;
    logic                               empty;

    modport slave (
        input  dispatch_valid, dispatch_rd, dispatch_pc,
        input  cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target,
        input  lookup_tag_a, lookup_tag_b,
        output dispatch_ready, dispatch_tag,
        output lookup_ready_a, lookup_ready_b, lookup_value_a, lookup_value_b,
        output commit_valid, commit_rd, commit_value, commit_tag,
        output flush, flush_pc, empty
    );

    modport master (
        output dispatch_valid, dispatch_rd, dispatch_pc,
        output cdb_valid, cdb_tag, cdb_value, cdb_mispredict, cdb_target,
        output lookup_tag_a, lookup_tag_b,
        input  dispatch_ready, dispatch_tag,
        input  lookup_ready_a, lookup_ready_b, lookup_value_a, lookup_value_b,
        input  commit_valid, commit_rd, commit_value, commit_tag,
        input  flush, flush_pc, empty
    );

endinterface

// File: rtl/reorder_buffer_rob_wrap_ptr.sv
// Modulo-Depth pointer advancing by 0..MaxInc per cycle, with synchronous clear.
module rob_wrap_ptr #(
    parameter int unsigned Depth  = 8,
    parameter int unsigned MaxInc = 2,
    localparam int unsigned PtrW  = $clog2(Depth),
    localparam int unsigned IncW  = $clog2(MaxInc + 1)
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            clear_i,
    input  logic [IncW-1:0] inc_i,
    output logic [PtrW-1:0] ptr_o
);

    localparam int unsigned SumW = PtrW + 1;

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [SumW-1:0] sum;

    // ptr + inc stays below 2*Depth, so one conditional subtract wraps it.
    always_comb begin
        sum = {1'b0, ptr_q} + SumW'(inc_i);
        if (sum >= SumW'(Depth)) begin
            ptr_d = PtrW'(sum - SumW'(Depth));
        end else begin
            ptr_d = PtrW'(sum);
        end
        if (clear_i) begin
            ptr_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: in-order allocation, CDB capture, operand lookup with bypass,
// in-order retirement of up to COMMIT_WIDTH entries and flush on retired mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
    parameter int unsigned DEPTH        = ROB_SIZE,
    parameter int unsigned DATA_WIDTH   = DATA_SIZE,
    parameter int unsigned ADDR_WIDTH   = ADDRESS_SIZE,
    parameter int unsigned REG_WIDTH    = 5,
    parameter int unsigned COMMIT_WIDTH = 2,
    parameter int unsigned TAG_WIDTH    = rob_tag_width(DEPTH)
) (
    input logic             clk,
    input logic             reset,
    reorder_buffer_if.slave bus
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned RetW = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    rob_entry_t          entries_q [DEPTH];
    rob_entry_t          entries_d [DEPTH];
    logic [CntW-1:0]     count_q, count_d;
    logic [PtrW-1:0]     head, tail, head1;
    logic [PtrW-1:0]     slot_idx [2];
    logic                ret [2];
    logic [RetW-1:0]     num_ret;
    logic                flush;
    logic                do_dispatch;
    logic                cdb_hit;
    logic [PtrW-1:0]     cdb_idx;
    logic [TAG_WIDTH-1:0] lk_tag [2];
    logic                lk_ready [2];
    logic [DATA_WIDTH-1:0] lk_value [2];

    assign head1       = (head == PtrW'(DEPTH - 1)) ? '0 : head + PtrW'(1);
    assign slot_idx[0] = head;
    assign slot_idx[1] = head1;

    // Slot 1 never retires behind a mispredict, so at most one flush source exists.
    always_comb begin
        ret[0] = entries_q[head].busy && entries_q[head].done;
        ret[1] = (COMMIT_WIDTH == 2) && ret[0] && !entries_q[head].mispredict &&
                 entries_q[head1].busy && entries_q[head1].done;
        num_ret = RetW'(ret[0]) + RetW'(ret[1]);
    end

    always_comb begin
        bus.commit_valid = '0;
        bus.commit_rd    = '0;
        bus.commit_value = '0;
        bus.commit_tag   = '0;
        flush            = 1'b0;
        bus.flush_pc     = '0;
        for (int s = 0; s < COMMIT_WIDTH; s++) begin
            if (ret[s]) begin
                bus.commit_valid[s] = 1'b1;
                bus.commit_rd[s*REG_WIDTH +: REG_WIDTH] =
                    REG_WIDTH'(entries_q[slot_idx[s]].rd);
                bus.commit_value[s*DATA_WIDTH +: DATA_WIDTH] =
                    DATA_WIDTH'(entries_q[slot_idx[s]].value);
                bus.commit_tag[s*TAG_WIDTH +: TAG_WIDTH] =
                    TAG_WIDTH'(slot_idx[s]) + TAG_WIDTH'(1);
                if (entries_q[slot_idx[s]].mispredict) begin
                    flush        = 1'b1;
                    bus.flush_pc = ADDR_WIDTH'(entries_q[slot_idx[s]].target);
                end
            end
        end
    end

    assign bus.flush          = flush;
    assign bus.empty          = (count_q == '0);
    assign bus.dispatch_ready = (count_q != CntW'(DEPTH)) && !flush;
    assign bus.dispatch_tag   = TAG_WIDTH'(tail) + TAG_WIDTH'(1);
    assign do_dispatch        = bus.dispatch_valid && bus.dispatch_ready;

    assign cdb_idx = PtrW'(bus.cdb_tag - TAG_WIDTH'(1));
    assign cdb_hit = bus.cdb_valid && (bus.cdb_tag != '0) &&
                     (bus.cdb_tag <= TAG_WIDTH'(DEPTH)) && entries_q[cdb_idx].busy;

    assign lk_tag[0] = bus.lookup_tag_a;
    assign lk_tag[1] = bus.lookup_tag_b;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            lk_ready[i] = 1'b0;
            lk_value[i] = '0;
            if (lk_tag[i] != '0) begin
                if (bus.cdb_valid && (bus.cdb_tag == lk_tag[i])) begin
                    lk_ready[i] = 1'b1;
                    lk_value[i] = bus.cdb_value;
                end else if ((lk_tag[i] <= TAG_WIDTH'(DEPTH)) &&
                             entries_q[PtrW'(lk_tag[i] - TAG_WIDTH'(1))].busy &&
                             entries_q[PtrW'(lk_tag[i] - TAG_WIDTH'(1))].done) begin
                    lk_ready[i] = 1'b1;
                    lk_value[i] =
                        DATA_WIDTH'(entries_q[PtrW'(lk_tag[i] - TAG_WIDTH'(1))].value);
                end
            end
        end
    end

    assign bus.lookup_ready_a = lk_ready[0];
    assign bus.lookup_ready_b = lk_ready[1];
    assign bus.lookup_value_a = lk_value[0];
    assign bus.lookup_value_b = lk_value[1];

    // Order matters: CDB capture, then retire clear, then allocation at tail.
    always_comb begin
        entries_d = entries_q;
        if (cdb_hit) begin
            entries_d[cdb_idx].done       = 1'b1;
            entries_d[cdb_idx].value      = DATA_SIZE'(bus.cdb_value);
            entries_d[cdb_idx].mispredict = bus.cdb_mispredict;
            entries_d[cdb_idx].target     = ADDRESS_SIZE'(bus.cdb_target);
        end
        for (int s = 0; s < 2; s++) begin
            if (ret[s]) begin
                entries_d[slot_idx[s]] = '0;
            end
        end
        if (do_dispatch) begin
            entries_d[tail]      = '0;
            entries_d[tail].busy = 1'b1;
            entries_d[tail].rd   = REG_SIZE'(bus.dispatch_rd);
            entries_d[tail].pc   = ADDRESS_SIZE'(bus.dispatch_pc);
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_d[i] = '0;
            end
        end
        count_d = flush ? '0 : count_q + CntW'(do_dispatch) - CntW'(num_ret);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            count_q <= '0;
        end else begin
            entries_q <= entries_d;
            count_q   <= count_d;
        end
    end

    rob_wrap_ptr #(
        .Depth  (DEPTH),
        .MaxInc (COMMIT_WIDTH)
    ) u_head_ptr (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (flush),
        .inc_i   (num_ret),
        .ptr_o   (head)
    );

    rob_wrap_ptr #(
        .Depth  (DEPTH),
        .MaxInc (COMMIT_WIDTH)
    ) u_tail_ptr (
        .clk_i   (clk),
        .reset_i (reset),
        .clear_i (flush),
        .inc_i   (RetW'(do_dispatch)),
        .ptr_o   (tail)
    );

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model.
module tb_reorder_buffer;

    localparam int D  = 4;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 2;
    localparam int TW = $clog2(D + 1);

    typedef struct {
        int            tag;
        logic [RW-1:0] rd;
        logic [DW-1:0] value;
        logic [AW-1:0] target;
        bit            done;
        bit            mp;
    } ment_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer_if #(
        .DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW), .COMMIT_WIDTH(CW)
    ) bus ();

    reorder_buffer #(
        .DEPTH(D), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REG_WIDTH(RW), .COMMIT_WIDTH(CW)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;
    ment_t q[$];
    int tail = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic idle();
        bus.dispatch_valid = 0; bus.dispatch_rd = '0; bus.dispatch_pc = '0;
        bus.cdb_valid = 0; bus.cdb_tag = '0; bus.cdb_value = '0;
        bus.cdb_mispredict = 0; bus.cdb_target = '0;
        bus.lookup_tag_a = '0; bus.lookup_tag_b = '0;
        reset = 0;
    endtask

    task automatic disp(input int rd, input int pc);
        bus.dispatch_valid = 1; bus.dispatch_rd = RW'(rd); bus.dispatch_pc = AW'(pc);
    endtask

    task automatic cdb(input int tag, input int val, input bit mp, input int tgt);
        bus.cdb_valid = 1; bus.cdb_tag = TW'(tag); bus.cdb_value = DW'(val);
        bus.cdb_mispredict = mp; bus.cdb_target = AW'(tgt);
    endtask

    task automatic model_lookup(input int t, output bit r, output logic [DW-1:0] v);
        r = 0; v = '0;
        if (t != 0) begin
            if (bus.cdb_valid && int'(bus.cdb_tag) == t) begin
                r = 1; v = bus.cdb_value;
            end else begin
                foreach (q[i]) if (q[i].tag == t && q[i].done) begin
                    r = 1; v = q[i].value;
                end
            end
        end
    endtask

    // Compare all outputs against the model at negedge, then advance the model.
    task automatic cycle();
        logic [CW-1:0]    e_cv;
        logic [CW*RW-1:0] e_rd;
        logic [CW*DW-1:0] e_val;
        logic [CW*TW-1:0] e_tag;
        logic [AW-1:0]    e_fpc;
        logic [DW-1:0]    lv;
        bit e_fl, e_rdy, lr;
        int nret;
        ment_t m;
        @(negedge clk);
        nret = 0; e_fl = 0; e_fpc = '0; e_cv = '0; e_rd = '0; e_val = '0; e_tag = '0;
        if (q.size() > 0 && q[0].done) begin
            nret = 1;
            if (q[0].mp) begin
                e_fl = 1; e_fpc = q[0].target;
            end else if (q.size() > 1 && q[1].done) begin
                nret = 2;
                if (q[1].mp) begin
                    e_fl = 1; e_fpc = q[1].target;
                end
            end
        end
        for (int s = 0; s < nret; s++) begin
            e_cv[s] = 1'b1;
            e_rd[s*RW +: RW] = q[s].rd;
            e_val[s*DW +: DW] = q[s].value;
            e_tag[s*TW +: TW] = TW'(q[s].tag);
        end
        e_rdy = (q.size() != D) && !e_fl;
        check_eq("commit_valid", 64'(bus.commit_valid), 64'(e_cv));
        check_eq("commit_rd", 64'(bus.commit_rd), 64'(e_rd));
        check_eq("commit_value", 64'(bus.commit_value), 64'(e_val));
        check_eq("commit_tag", 64'(bus.commit_tag), 64'(e_tag));
        check_eq("flush", 64'(bus.flush), 64'(e_fl));
        check_eq("flush_pc", 64'(bus.flush_pc), 64'(e_fpc));
        check_eq("dispatch_ready", 64'(bus.dispatch_ready), 64'(e_rdy));
        check_eq("dispatch_tag", 64'(bus.dispatch_tag), 64'(tail + 1));
        check_eq("empty", 64'(bus.empty), 64'(q.size() == 0));
        model_lookup(int'(bus.lookup_tag_a), lr, lv);
        check_eq("lookup_ready_a", 64'(bus.lookup_ready_a), 64'(lr));
        check_eq("lookup_value_a", 64'(bus.lookup_value_a), 64'(lv));
        model_lookup(int'(bus.lookup_tag_b), lr, lv);
        check_eq("lookup_ready_b", 64'(bus.lookup_ready_b), 64'(lr));
        check_eq("lookup_value_b", 64'(bus.lookup_value_b), 64'(lv));

        if (reset || e_fl) begin
            q.delete(); tail = 0;
        end else begin
            if (bus.cdb_valid) begin
                foreach (q[i]) if (q[i].tag == int'(bus.cdb_tag)) begin
                    m = q[i];
                    m.done = 1; m.value = bus.cdb_value;
                    m.mp = bus.cdb_mispredict; m.target = bus.cdb_target;
                    q[i] = m;
                end
            end
            repeat (nret) void'(q.pop_front());
            if (bus.dispatch_valid && e_rdy) begin
                m = '{tag: tail + 1, rd: bus.dispatch_rd, value: '0, target: '0, done: 0, mp: 0};
                q.push_back(m);
                tail = (tail + 1) % D;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle(); reset = 1; cycle(); idle();
    endtask

    initial begin
        idle();
        @(posedge clk); #1;

        // Reset state and in-order two-wide commit.
        do_reset();
        #1;
        check_eq("rst_tag", 64'(bus.dispatch_tag), 64'd1);
        check_eq("rst_empty", 64'(bus.empty), 64'd1);
        disp(5, 'h100); cycle();
        disp(6, 'h104); cycle();
        disp(7, 'h108); cycle();
        idle(); cdb(2, 'h22, 0, 0); cycle();
        idle(); cdb(1, 'h11, 0, 0); #1;
        check_eq("no_commit_tag2_only", 64'(bus.commit_valid), 64'd0);
        cycle();
        idle(); #1;
        check_eq("pair_valid", 64'(bus.commit_valid), 64'h3);
        check_eq("pair_rd", 64'(bus.commit_rd), {54'd0, 5'd6, 5'd5});
        check_eq("pair_value", 64'(bus.commit_value), {32'h22, 32'h11});
        cycle();
        idle(); #1;
        check_eq("tag3_pending", 64'(bus.commit_valid), 64'd0);
        cdb(3, 'h33, 0, 0); cycle();
        idle(); cycle(); cycle();

        // Full, ignored dispatch, retire one, wrap tag to 1, CDB bypass.
        do_reset();
        for (int i = 0; i < D; i++) begin
            disp(10 + i, 'h200 + 4 * i); cycle();
        end
        disp(20, 'h300); #1;
        check_eq("full_not_ready", 64'(bus.dispatch_ready), 64'd0);
        cycle();
        idle(); cdb(1, 'h55, 0, 0); cycle();
        idle(); disp(21, 'h304); #1;
        check_eq("commit_no_slot", 64'(bus.dispatch_ready), 64'd0);
        cycle();
        idle(); disp(22, 'h308); #1;
        check_eq("wrap_tag", 64'(bus.dispatch_tag), 64'd1);
        cycle();
        idle(); cdb(2, 'hAB, 0, 0); bus.lookup_tag_a = TW'(2); bus.lookup_tag_b = '0; #1;
        check_eq("bypass_ready", 64'(bus.lookup_ready_a), 64'd1);
        check_eq("bypass_value", 64'(bus.lookup_value_a), 64'hAB);
        check_eq("tag0_ready", 64'(bus.lookup_ready_b), 64'd0);
        cycle();

        // Mispredict at head flushes younger done entries.
        do_reset();
        disp(1, 'h10); cycle();
        disp(2, 'h14); cycle();
        disp(3, 'h18); cycle();
        idle(); cdb(2, 'h2, 0, 0); cycle();
        idle(); cdb(3, 'h3, 0, 0); cycle();
        idle(); cdb(1, 'h1, 1, 'h1000); cycle();
        idle(); #1;
        check_eq("mp_commit", 64'(bus.commit_valid), 64'd1);
        check_eq("mp_flush", 64'(bus.flush), 64'd1);
        check_eq("mp_flush_pc", 64'(bus.flush_pc), 64'h1000);
        cycle();
        idle(); #1;
        check_eq("post_flush_empty", 64'(bus.empty), 64'd1);
        check_eq("post_flush_tag", 64'(bus.dispatch_tag), 64'd1);

        // Reset mid-run with traffic.
        disp(4, 'h20); cycle();
        disp(5, 'h24); cycle();
        disp(6, 'h28); cycle();
        disp(7, 'h2c); cdb(1, 'h9, 0, 0); reset = 1; cycle();
        idle(); #1;
        check_eq("midrst_empty", 64'(bus.empty), 64'd1);
        check_eq("midrst_commit", 64'(bus.commit_valid), 64'd0);
        check_eq("midrst_ready", 64'(bus.dispatch_ready), 64'd1);
        check_eq("midrst_flush", 64'(bus.flush), 64'd0);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            idle();
            if ($urandom_range(99) < 60) disp($urandom_range(31), $urandom);
            if ($urandom_range(99) < 60) begin
                int t;
                if (q.size() > 0 && $urandom_range(3) != 0)
                    t = q[$urandom_range(q.size() - 1)].tag;
                else
                    t = $urandom_range((1 << TW) - 1);
                cdb(t, $urandom, $urandom_range(9) == 0, $urandom);
            end
            bus.lookup_tag_a = TW'($urandom_range((1 << TW) - 1));
            bus.lookup_tag_b = TW'($urandom_range((1 << TW) - 1));
            reset = ($urandom_range(99) == 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
